// File: rtl/serial_addsub_seq.sv
// Bit-serial WIDTH-bit adder/subtractor sequencer: feeds one operand bit pair per clock
// LSB-first through a full-adder/full-subtractor cell and holds carry/borrow between bits.
module serial_addsub_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [CW-1:0]    cnt_r;
    logic             op_r;
    logic             c_r;
    logic             a_msb_r;
    logic             b_msb_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] result_r;
    logic             cout_r;
    logic             ovf_r;
    logic             accept_s;
    logic             last_s;
    logic             s_s;
    logic             c_next_s;
    logic             ovf_s;

    function automatic logic cell_sum(input logic a, input logic b, input logic c);
        return a ^ b ^ c;
    endfunction

    // Carry for add, borrow for subtract.
    function automatic logic cell_carry(input logic a, input logic b, input logic c,
                                        input logic sub);
        logic r;
        if (sub) begin
            r = (~a & b) | (~(a ^ b) & c);
        end else begin
            r = (a & b) | (a & c) | (b & c);
        end
        return r;
    endfunction

    function automatic logic signed_ovf(input logic sub, input logic a_msb,
                                        input logic b_msb, input logic r_msb);
        logic r;
        if (sub) begin
            r = (a_msb != b_msb) & (r_msb != a_msb);
        end else begin
            r = (a_msb == b_msb) & (r_msb != a_msb);
        end
        return r;
    endfunction

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;
    assign cout   = cout_r;
    assign ovf    = ovf_r;

    // Next-state logic and the current bit-cell evaluation.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        last_s   = (cnt_r == LAST_CNT);
        s_s      = cell_sum(a_sh_r[0], b_sh_r[0], c_r);
        c_next_s = cell_carry(a_sh_r[0], b_sh_r[0], c_r, op_r);
        ovf_s    = signed_ovf(op_r, a_msb_r, b_msb_r, s_s);
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s  = RUN;
                    accept_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath: A's shift register doubles as the sum register, sum bits enter at the MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_r   <= '0;
            b_sh_r   <= '0;
            cnt_r    <= '0;
            op_r     <= 1'b0;
            c_r      <= 1'b0;
            a_msb_r  <= 1'b0;
            b_msb_r  <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= '0;
            cout_r   <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            busy_r <= (state_s == RUN);
            done_r <= (state_s == DONE);
            if (accept_s) begin
                a_sh_r  <= a_in;
                b_sh_r  <= b_in;
                op_r    <= op_sub;
                c_r     <= 1'b0;
                cnt_r   <= '0;
                a_msb_r <= a_in[WIDTH-1];
                b_msb_r <= b_in[WIDTH-1];
            end else if (state_r == RUN) begin
                a_sh_r <= {s_s, a_sh_r[WIDTH-1:1]};
                b_sh_r <= {1'b0, b_sh_r[WIDTH-1:1]};
                c_r    <= c_next_s;
                cnt_r  <= cnt_r + CNT_ONE;
                if (last_s) begin
                    result_r <= {s_s, a_sh_r[WIDTH-1:1]};
                    cout_r   <= c_next_s;
                    ovf_r    <= ovf_s;
                end else begin
                    result_r <= result_r;
                end
            end else begin
                c_r <= c_r;
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub_seq.sv
// Self-checking bench for serial_addsub_seq (WIDTH=8): directed corner cases plus random
// operations compared against an integer-arithmetic reference model.
module tb_serial_addsub_seq;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             op_sub;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;

    int n_cmp = 0;
    int n_err = 0;

    serial_addsub_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op_sub(op_sub),
        .a_in  (a_in),
        .b_in  (b_in),
        .busy  (busy),
        .done  (done),
        .result(result),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic, signed range test for overflow.
    task automatic ref_model(input logic sub, input logic [7:0] a, input logic [7:0] b,
                             output logic [7:0] r, output logic c, output logic v);
        int ia, ib, sa, sb, full, sfull;
        ia = a;
        ib = b;
        sa = $signed(a);
        sb = $signed(b);
        if (sub) begin
            full  = ia - ib;
            sfull = sa - sb;
            c     = (ia < ib);
        end else begin
            full  = ia + ib;
            sfull = sa + sb;
            c     = (full > 255);
        end
        r = full[7:0];
        v = (sfull > 127) || (sfull < -128);
    endtask

    task automatic run_op(input logic sub, input logic [7:0] a, input logic [7:0] b,
                          input bit inject, input string tag);
        logic [7:0] exp_r;
        logic       exp_c;
        logic       exp_v;
        int         cyc;
        int         busy_cnt;
        bit         got;
        ref_model(sub, a, b, exp_r, exp_c, exp_v);
        @(negedge clk);
        start  = 1'b1;
        op_sub = sub;
        a_in   = a;
        b_in   = b;
        @(posedge clk);
        cyc      = 0;
        busy_cnt = 0;
        got      = 1'b0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                got = 1'b1;
            end else begin
                if (inject && cyc == 2) begin
                    start  = 1'b1;
                    op_sub = 1'b0;
                    a_in   = 8'h11;
                    b_in   = 8'h22;
                end else begin
                    start  = 1'b0;
                    a_in   = 8'($urandom);
                    b_in   = 8'($urandom);
                    op_sub = 1'($urandom);
                end
                @(posedge clk);
                cyc++;
            end
        end
        check_eq({tag, ":done_seen"}, 32'(got), 32'd1);
        if (got) begin
            check_eq({tag, ":latency"}, cyc, WIDTH);
            check_eq({tag, ":busy_cycles"}, busy_cnt, WIDTH);
            check_eq({tag, ":result"}, 32'(result), 32'(exp_r));
            check_eq({tag, ":cout"}, 32'(cout), 32'(exp_c));
            check_eq({tag, ":ovf"}, 32'(ovf), 32'(exp_v));
            // A start arriving in the DONE cycle must be dropped.
            if (inject) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check_eq({tag, ":done_single"}, 32'(done), 32'd0);
            check_eq({tag, ":busy_after"}, 32'(busy), 32'd0);
            check_eq({tag, ":result_held"}, 32'(result), 32'(exp_r));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int done_cnt;
        rst    = 1'b1;
        start  = 1'b1;
        op_sub = 1'b0;
        a_in   = 8'hAA;
        b_in   = 8'h55;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst:busy", 32'(busy), 32'd0);
        check_eq("rst:done", 32'(done), 32'd0);
        check_eq("rst:result", 32'(result), 32'd0);
        check_eq("rst:cout", 32'(cout), 32'd0);
        check_eq("rst:ovf", 32'(ovf), 32'd0);
        start = 1'b0;
        rst   = 1'b0;

        run_op(1'b0, 8'h0F, 8'h01, 1'b0, "add_0f_01");
        run_op(1'b0, 8'hFF, 8'h01, 1'b0, "add_ff_01");
        run_op(1'b0, 8'h7F, 8'h01, 1'b0, "add_7f_01");
        run_op(1'b1, 8'h05, 8'h03, 1'b0, "sub_05_03");
        run_op(1'b1, 8'h03, 8'h05, 1'b0, "sub_03_05");
        run_op(1'b1, 8'h80, 8'h01, 1'b0, "sub_80_01");
        run_op(1'b0, 8'hFF, 8'hFF, 1'b0, "add_ff_ff");
        run_op(1'b1, 8'h00, 8'hFF, 1'b0, "sub_00_ff");
        run_op(1'b0, 8'h0F, 8'h01, 1'b1, "ignored_start");

        // Reset in the fourth RUN cycle abandons the operation.
        @(negedge clk);
        start  = 1'b1;
        op_sub = 1'b0;
        a_in   = 8'h33;
        b_in   = 8'h44;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("midrst:busy", 32'(busy), 32'd0);
        check_eq("midrst:done", 32'(done), 32'd0);
        check_eq("midrst:result", 32'(result), 32'd0);
        check_eq("midrst:cout", 32'(cout), 32'd0);
        check_eq("midrst:ovf", 32'(ovf), 32'd0);
        rst      = 1'b0;
        done_cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check_eq("midrst:no_done", done_cnt, 0);
        run_op(1'b0, 8'h0A, 8'h05, 1'b0, "after_rst");

        for (int i = 0; i < 500; i++) begin
            run_op(1'($urandom), 8'($urandom), 8'($urandom), 1'b0, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
